exu_bjp_resolve: RTL and testbench
==================================

# exu_bjp_resolve

Branch/jump resolution unit at the EXU commit stage. It is the consuming end of the IFU static-prediction path. It compares the prediction carried with each committed B/J instruction against the resolved outcome. On a mispredict it raises a registered flush/redirect request to the IFU and holds it until the IFU acknowledges. It supplies the redirect target as two adder operands, so the IFU next-PC adder stays shared.

## Interface
Parameters: none. Widths come from `defines.v`:
- `PC_SIZE`: PC width.
- `XLEN`: datapath width.

Ports. Reset is asynchronous and active-low on `rst_n`; all state is clocked by `clk`.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmt_i_valid  in  1  commit-stage instruction valid
- cmt_i_ready  out  1  unit can accept an instruction
- cmt_i_pc  in  PC_SIZE  PC of the committing instruction
- cmt_i_rv32  in  1  1 = 32-bit instruction, 0 = 16-bit
- cmt_i_bjp  in  1  instruction is JAL, JALR or Bxx
- cmt_i_bjp_prdt  in  1  taken-prediction made by the IFU
- cmt_i_bjp_rslv  in  1  resolved taken outcome from the ALU
- cmt_i_imm  in  XLEN  B/J offset immediate
- flush_req  out  1  redirect request to the IFU
- flush_ack  in  1  IFU accepts the redirect
- flush_add_op1  out  PC_SIZE  redirect adder operand 1
- flush_add_op2  out  PC_SIZE  redirect adder operand 2
- bjp_cnt  out  32  resolved B/J count (present only with the Configuration macro)
- mispred_cnt  out  32  mispredict count (present only with the Configuration macro)

## Operation
- Accept: an instruction is accepted when `cmt_i_valid & cmt_i_ready`.
- Mispredict: `mis = accept & cmt_i_bjp & (cmt_i_bjp_prdt ^ cmt_i_bjp_rslv)`.
  - JAL/JALR arrive with `prdt = rslv = 1` and never mispredict.
- Redirect operands, registered on `mis`:
  - predicted taken, resolved not-taken: op1 = `cmt_i_pc`, op2 = 4 if `rv32`, else 2 (fall-through).
  - predicted not-taken, resolved taken: op1 = `cmt_i_pc`, op2 = `cmt_i_imm[PC_SIZE-1:0]` (target).
- State machine, 2 states:
  - IDLE: `cmt_i_ready = 1`, `flush_req = 0`. On `mis`, go to FLUSH.
  - FLUSH: `cmt_i_ready = 0`, `flush_req = 1`, operands held stable. On `flush_ack`, go to IDLE.
- Non-B/J instructions and correctly predicted B/J are accepted in IDLE with no side effect.
- `flush_ack` while in IDLE is ignored.
- The operand registers load only on `mis` and otherwise hold their last value.

## Timing
- Reset values: state = IDLE, `flush_req = 0`, `cmt_i_ready = 1`, `flush_add_op1/op2 = 0`, counters = 0.
- Latency: `flush_req` asserts the cycle after the mispredicting accept.
- Ack timing: `flush_ack` in the first FLUSH cycle returns to IDLE next cycle, so `flush_req` is high for exactly one cycle.
- While `flush_ack` stays low, `flush_req` and the operands remain constant indefinitely.
- The cycle after the ack, `cmt_i_ready = 1`, so a new instruction is accepted with no bubble.
- `cmt_i_valid` may drop while in FLUSH; this has no effect.
- `rst_n` asserted during FLUSH drops the pending request immediately (asynchronously); no redirect is issued.
- Every output is a function of registered state only. There is no combinational path from `cmt_i_*` or `flush_ack` to any output.

## Configuration
- Macro: `SIMPLECORE_BJP_PERF_CNT_EN`.
- Defined:
  - `bjp_cnt` increments on every accept with `cmt_i_bjp`.
  - `mispred_cnt` increments on every `mis`.
  - Both are 32 bits and wrap from `0xFFFFFFFF` to 0.
  - Both update in the cycle after the event.
- Undefined: both ports and their counter logic are absent. Nothing else changes.

## Structure
- `defines.v` holds:
  - `PC_SIZE` and `XLEN`.
  - The state encodings `BJP_RSLV_IDLE = 1'b0` and `BJP_RSLV_FLUSH = 1'b1`.
  - The fall-through increments `PC_INCR_32 = 4` and `PC_INCR_16 = 2`.
- Flops use `sirv_gnrl_dfflr` (async active-low reset, load enable).
- One sub-module, `exu_bjp_perf_cnt`, holds the two wrapping counters. It is instantiated only under the macro.

## Test plan
- Bxx predicted taken, resolved not-taken; `pc = 0x1000`, `rv32 = 1` -> next cycle `flush_req = 1`, op1 = `0x1000`, op2 = 4; `cmt_i_ready = 0`.
- Bxx predicted not-taken, resolved taken; `pc = 0x2002`, `imm = 0x40`, `rv32 = 0` -> op1 = `0x2002`, op2 = `0x40`. Hold `flush_ack` low for 5 cycles: request and operands stable. Ack: `flush_req = 0` next cycle, `ready = 1`.
- JAL (`prdt = rslv = 1`), then correctly predicted Bxx, then ALU op, back-to-back -> all accepted, `flush_req` stays 0.
- Mispredict with `flush_ack` already high in the first FLUSH cycle -> `flush_req` is a 1-cycle pulse. A second mispredict on the next cycle is accepted and raises a new request with new operands.
- Assert `rst_n` low mid-FLUSH -> `flush_req = 0` immediately. After release: IDLE, `ready = 1`, outputs 0.
- With the macro defined: preload `mispred_cnt = 0xFFFFFFFF` via forced state, apply one mispredict -> `mispred_cnt = 0`, `bjp_cnt` +1.

Source files
------------

// File: rtl/exu_bjp_resolve_pkg.sv
// Shared widths, state encoding and fall-through increments for the B/J resolution unit.
package exu_bjp_resolve_pkg;

    localparam int PC_SIZE     = 32;
    localparam int XLEN        = 32;
    localparam int PERF_CNT_W  = 32;

    typedef enum logic {
        BJP_RSLV_IDLE  = 1'b0,
        BJP_RSLV_FLUSH = 1'b1
    } bjp_rslv_state_e;

    localparam logic [PC_SIZE-1:0] PC_INCR_32 = PC_SIZE'(4);
    localparam logic [PC_SIZE-1:0] PC_INCR_16 = PC_SIZE'(2);

    function automatic logic [PC_SIZE-1:0] fallthru_incr(input logic rv32);
        return rv32 ? PC_INCR_32 : PC_INCR_16;
    endfunction

endpackage

// File: rtl/exu_bjp_perf_cnt.sv
// Wrapping B/J and mispredict event counters.
// Compiled only when SIMPLECORE_BJP_PERF_CNT_EN is defined.
`ifdef SIMPLECORE_BJP_PERF_CNT_EN
module exu_bjp_perf_cnt
    import exu_bjp_resolve_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_bjp_evt,
    input  logic                  i_mis_evt,
    output logic [PERF_CNT_W-1:0] o_bjp_cnt,
    output logic [PERF_CNT_W-1:0] o_mispred_cnt
);

    logic [PERF_CNT_W-1:0] w_bjp_cnt_nxt;
    logic [PERF_CNT_W-1:0] w_mispred_cnt_nxt;

    // Natural modular add gives the 0xFFFFFFFF -> 0 wrap.
    assign w_bjp_cnt_nxt     = o_bjp_cnt + PERF_CNT_W'(1);
    assign w_mispred_cnt_nxt = o_mispred_cnt + PERF_CNT_W'(1);

    sirv_gnrl_dfflr #(.DW(PERF_CNT_W)) u_bjp_dff (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_lden  (i_bjp_evt),
        .i_dnxt  (w_bjp_cnt_nxt),
        .o_qout  (o_bjp_cnt)
    );

    sirv_gnrl_dfflr #(.DW(PERF_CNT_W)) u_mispred_dff (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_lden  (i_mis_evt),
        .i_dnxt  (w_mispred_cnt_nxt),
        .o_qout  (o_mispred_cnt)
    );

endmodule
`endif

// File: rtl/sirv_gnrl_dfflr.sv
// Generic flop with load enable and asynchronous active-low reset to zero.
module sirv_gnrl_dfflr #(
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_lden,
    input  logic [DW-1:0] i_dnxt,
    output logic [DW-1:0] o_qout
);

    logic [DW-1:0] r_qout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_qout <= '0;
        end else if (i_lden) begin
            r_qout <= i_dnxt;
        end
    end

    assign o_qout = r_qout;

endmodule

// File: rtl/exu_bjp_resolve.sv
// Commit-stage branch/jump resolution: registered flush/redirect request to the IFU.
// Optional perf counters enabled by SIMPLECORE_BJP_PERF_CNT_EN.
module exu_bjp_resolve
    import exu_bjp_resolve_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmt_i_valid,
    output logic               cmt_i_ready,
    input  logic [PC_SIZE-1:0] cmt_i_pc,
    input  logic               cmt_i_rv32,
    input  logic               cmt_i_bjp,
    input  logic               cmt_i_bjp_prdt,
    input  logic               cmt_i_bjp_rslv,
    input  logic [XLEN-1:0]    cmt_i_imm,
    output logic               flush_req,
    input  logic               flush_ack,
    output logic [PC_SIZE-1:0] flush_add_op1,
    output logic [PC_SIZE-1:0] flush_add_op2
`ifdef SIMPLECORE_BJP_PERF_CNT_EN
   ,output logic [PERF_CNT_W-1:0] bjp_cnt
   ,output logic [PERF_CNT_W-1:0] mispred_cnt
`endif
);

    bjp_rslv_state_e    r_state;
    bjp_rslv_state_e    w_state_nxt;
    logic               w_state_q;
    logic               w_state_ena;
    logic               w_idle;
    logic               w_accept;
    logic               w_mis;
    logic [PC_SIZE-1:0] w_op2_nxt;

    assign r_state  = bjp_rslv_state_e'(w_state_q);
    assign w_idle   = (r_state == BJP_RSLV_IDLE);

    // Outputs depend on registered state only; no input-to-output path.
    assign cmt_i_ready = w_idle;
    assign flush_req   = ~w_idle;

    assign w_accept = cmt_i_valid & w_idle;
    assign w_mis    = w_accept & cmt_i_bjp & (cmt_i_bjp_prdt ^ cmt_i_bjp_rslv);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BJP_RSLV_IDLE:  if (w_mis)     w_state_nxt = BJP_RSLV_FLUSH;
            BJP_RSLV_FLUSH: if (flush_ack) w_state_nxt = BJP_RSLV_IDLE;
            default:                       w_state_nxt = BJP_RSLV_IDLE;
        endcase
    end

    assign w_state_ena = (w_state_nxt != r_state);

    sirv_gnrl_dfflr #(.DW(1)) u_state_dff (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_lden  (w_state_ena),
        .i_dnxt  (w_state_nxt),
        .o_qout  (w_state_q)
    );

    // Resolved taken -> branch target offset; resolved not-taken -> fall-through size.
    assign w_op2_nxt = cmt_i_bjp_rslv ? cmt_i_imm[PC_SIZE-1:0] : fallthru_incr(cmt_i_rv32);

    sirv_gnrl_dfflr #(.DW(PC_SIZE)) u_op1_dff (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_lden  (w_mis),
        .i_dnxt  (cmt_i_pc),
        .o_qout  (flush_add_op1)
    );

    sirv_gnrl_dfflr #(.DW(PC_SIZE)) u_op2_dff (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_lden  (w_mis),
        .i_dnxt  (w_op2_nxt),
        .o_qout  (flush_add_op2)
    );

`ifdef SIMPLECORE_BJP_PERF_CNT_EN
    logic w_bjp_evt;

    assign w_bjp_evt = w_accept & cmt_i_bjp;

    exu_bjp_perf_cnt u_perf_cnt (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_bjp_evt     (w_bjp_evt),
        .i_mis_evt     (w_mis),
        .o_bjp_cnt     (bjp_cnt),
        .o_mispred_cnt (mispred_cnt)
    );
`endif

endmodule

// File: tb/tb_exu_bjp_resolve.sv
// Self-checking bench for exu_bjp_resolve with a behavioural redirect model.
module tb_exu_bjp_resolve;

    logic        clk;
    logic        rst_n;
    logic        vld;
    logic        ready;
    logic [31:0] pc;
    logic        rv32;
    logic        bjp;
    logic        prdt;
    logic        rslv;
    logic [31:0] imm;
    logic        flush_req;
    logic        ack;
    logic [31:0] op1;
    logic [31:0] op2;
`ifdef SIMPLECORE_BJP_PERF_CNT_EN
    logic [31:0] bjp_cnt;
    logic [31:0] mispred_cnt;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: pending redirect plus the operands it carries.
    bit          m_flush;
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    logic [31:0] m_bjp_cnt;
    logic [31:0] m_mis_cnt;

    exu_bjp_resolve dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmt_i_valid    (vld),
        .cmt_i_ready    (ready),
        .cmt_i_pc       (pc),
        .cmt_i_rv32     (rv32),
        .cmt_i_bjp      (bjp),
        .cmt_i_bjp_prdt (prdt),
        .cmt_i_bjp_rslv (rslv),
        .cmt_i_imm      (imm),
        .flush_req      (flush_req),
        .flush_ack      (ack),
        .flush_add_op1  (op1),
        .flush_add_op2  (op2)
`ifdef SIMPLECORE_BJP_PERF_CNT_EN
       ,.bjp_cnt        (bjp_cnt)
       ,.mispred_cnt    (mispred_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_flush = 0; m_op1 = '0; m_op2 = '0; m_bjp_cnt = '0; m_mis_cnt = '0;
    endtask

    task automatic drv(input logic v, input logic [31:0] p, input logic r32,
                       input logic b, input logic pr, input logic rs, input logic [31:0] im);
        vld = v; pc = p; rv32 = r32; bjp = b; prdt = pr; rslv = rs; imm = im;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic step();
        if (m_flush) begin
            if (ack) m_flush = 0;
        end else if (vld) begin
            if (bjp) m_bjp_cnt = m_bjp_cnt + 1;
            if (bjp && (prdt != rslv)) begin
                m_flush   = 1;
                m_op1     = pc;
                m_op2     = rslv ? imm : (rv32 ? 32'd4 : 32'd2);
                m_mis_cnt = m_mis_cnt + 1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 0; ack = 0;
        drv(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (flush_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b want 0", flush_req); end
        n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", ready); end
        n_cmp++; if (op1 !== 32'h0) begin n_fail++; $display("FAIL rst_op1: got %h want 0", op1); end
        n_cmp++; if (op2 !== 32'h0) begin n_fail++; $display("FAIL rst_op2: got %h want 0", op2); end
`ifdef SIMPLECORE_BJP_PERF_CNT_EN
        n_cmp++; if (mispred_cnt !== 32'h0 || bjp_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_cnt: got %h/%h want 0/0", bjp_cnt, mispred_cnt); end
`endif
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_taken_not_taken();
        drv(1, 32'h1000, 1, 1, 1, 0, 32'h0);
        step();
        drv(0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (flush_req !== 1'b1) begin n_fail++; $display("FAIL tnt_req: got %0b want 1", flush_req); end
        n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL tnt_ready: got %0b want 0", ready); end
        n_cmp++; if (op1 !== 32'h1000) begin n_fail++; $display("FAIL tnt_op1: got %h want 1000", op1); end
        n_cmp++; if (op2 !== 32'h4) begin n_fail++; $display("FAIL tnt_op2: got %h want 4", op2); end
        ack = 1; step(); ack = 0;
        n_cmp++; if (flush_req !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL tnt_ack: got req=%0b rdy=%0b want 0/1", flush_req, ready); end
    endtask

    task automatic test_not_taken_taken_hold();
        drv(1, 32'h2002, 0, 1, 0, 1, 32'h40);
        step();
        // Garbage and repeated mispredicts during FLUSH must be ignored.
        for (int i = 0; i < 5; i++) begin
            drv(1'($urandom), $urandom, 1'($urandom), 1, 0, 1, $urandom);
            n_cmp++; if (flush_req !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d]: got req=%0b rdy=%0b want 1/0", i, flush_req, ready); end
            n_cmp++; if (op1 !== 32'h2002 || op2 !== 32'h40) begin n_fail++; $display("FAIL hold_ops[%0d]: got %h/%h want 2002/40", i, op1, op2); end
            step();
        end
        drv(0, 0, 0, 0, 0, 0, 0);
        ack = 1; step(); ack = 0;
        n_cmp++; if (flush_req !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL hold_ack: got req=%0b rdy=%0b want 0/1", flush_req, ready); end
        n_cmp++; if (op1 !== 32'h2002 || op2 !== 32'h40) begin n_fail++; $display("FAIL hold_keep: got %h/%h want 2002/40", op1, op2); end
    endtask

    task automatic test_back_to_back();
        drv(1, 32'h3000, 1, 1, 1, 1, 32'h80);  // JAL
        step();
        n_cmp++; if (flush_req !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL b2b_jal: got req=%0b rdy=%0b want 0/1", flush_req, ready); end
        drv(1, 32'h3004, 1, 1, 0, 0, 32'h10);  // Bxx correctly predicted
        step();
        n_cmp++; if (flush_req !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL b2b_bxx: got req=%0b rdy=%0b want 0/1", flush_req, ready); end
        drv(1, 32'h3008, 1, 0, 1, 0, 32'h20);  // ALU op with stray prediction bits
        step();
        drv(0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (flush_req !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL b2b_alu: got req=%0b rdy=%0b want 0/1", flush_req, ready); end
        n_cmp++; if (op1 !== m_op1 || op2 !== m_op2) begin n_fail++; $display("FAIL b2b_ops: got %h/%h want %h/%h", op1, op2, m_op1, m_op2); end
    endtask

    task automatic test_ack_first_cycle();
        ack = 1;  // ack in IDLE is ignored
        drv(1, 32'h5000, 0, 1, 1, 0, 32'h0);
        step();
        drv(0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (flush_req !== 1'b1 || op1 !== 32'h5000 || op2 !== 32'h2) begin n_fail++; $display("FAIL ack1_req: got req=%0b %h/%h want 1 5000/2", flush_req, op1, op2); end
        step();
        n_cmp++; if (flush_req !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL ack1_pulse: got req=%0b rdy=%0b want 0/1", flush_req, ready); end
        ack = 0;
        drv(1, 32'h6004, 1, 1, 0, 1, 32'h100);
        step();
        drv(0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (flush_req !== 1'b1 || op1 !== 32'h6004 || op2 !== 32'h100) begin n_fail++; $display("FAIL ack1_second: got req=%0b %h/%h want 1 6004/100", flush_req, op1, op2); end
        ack = 1; step(); ack = 0;
    endtask

    task automatic test_reset_mid_flush();
        drv(1, 32'h7000, 1, 1, 1, 0, 32'h0);
        step();
        drv(0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (flush_req !== 1'b1) begin n_fail++; $display("FAIL rmf_pre: got %0b want 1", flush_req); end
        #2 rst_n = 0;
        #1;
        n_cmp++; if (flush_req !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL rmf_async: got req=%0b rdy=%0b want 0/1", flush_req, ready); end
        model_reset();
        @(posedge clk); #3 rst_n = 1;
        @(posedge clk); #1;
        n_cmp++; if (flush_req !== 1'b0 || ready !== 1'b1 || op1 !== 32'h0 || op2 !== 32'h0) begin n_fail++; $display("FAIL rmf_post: got req=%0b rdy=%0b %h/%h want 0/1 0/0", flush_req, ready, op1, op2); end
    endtask

`ifdef SIMPLECORE_BJP_PERF_CNT_EN
    task automatic test_perf_wrap();
        force dut.u_perf_cnt.u_mispred_dff.r_qout = 32'hFFFF_FFFF;
        #1 release dut.u_perf_cnt.u_mispred_dff.r_qout;
        m_mis_cnt = 32'hFFFF_FFFF;
        drv(1, 32'h8000, 1, 1, 0, 1, 32'h8);
        step();
        drv(0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (mispred_cnt !== 32'h0) begin n_fail++; $display("FAIL perf_wrap: got %h want 0", mispred_cnt); end
        n_cmp++; if (bjp_cnt !== m_bjp_cnt) begin n_fail++; $display("FAIL perf_bjp: got %h want %h", bjp_cnt, m_bjp_cnt); end
        ack = 1; step(); ack = 0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drv(($urandom % 4) != 0, {$urandom, 1'b0}, 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), $urandom);
            ack = ($urandom % 3) == 0;
            step();
            n_cmp++; if (flush_req !== m_flush || ready !== !m_flush) begin n_fail++; $display("FAIL rnd_ctl[%0d]: got req=%0b rdy=%0b want %0b/%0b", i, flush_req, ready, m_flush, !m_flush); end
            n_cmp++; if (op1 !== m_op1 || op2 !== m_op2) begin n_fail++; $display("FAIL rnd_ops[%0d]: got %h/%h want %h/%h", i, op1, op2, m_op1, m_op2); end
`ifdef SIMPLECORE_BJP_PERF_CNT_EN
            n_cmp++; if (bjp_cnt !== m_bjp_cnt || mispred_cnt !== m_mis_cnt) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %h/%h want %h/%h", i, bjp_cnt, mispred_cnt, m_bjp_cnt, m_mis_cnt); end
`endif
        end
        ack = 0;
        drv(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_taken_not_taken();
        test_not_taken_taken_hold();
        test_back_to_back();
        test_ack_first_cycle();
        test_reset_mid_flush();
`ifdef SIMPLECORE_BJP_PERF_CNT_EN
        test_perf_wrap();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
